pcs_block_lock_ctrl: RTL and testbench

- Parametrised 64b/66b receive block-lock controller; next generation of the PCS lock state machine.
- Sits between gearbox/header extractor and descrambler.
- Counts sync headers per window and asserts block lock; commands gearbox bit-slips.
- Adds: IEEE 802.3 Cl.49 unlocked-slip rule, post-slip settle wait, lock-lost pulse, saturating slip counter, configurable thresholds.

---
 rtl/pcs_block_lock_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pcs_block_lock_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_block_lock_ctrl.sv
// rtl/pcs_block_lock_ctrl.sv - 64b/66b receive block-lock controller with gearbox slip control
//
// Counts sync headers per test window. Block lock is asserted after a window with no
// invalid headers. While unlocked, a single bad header triggers a slip. While locked,
// SH_INVALID_MAX bad headers in one window trigger a slip. After each slip, headers are
// ignored for SLIP_WAIT_CYCLES cycles so the gearbox can realign.
//
// Ports:
//   i_clk          core clock
//   i_reset        asynchronous, active-high reset
//   i_header[1:0]  sync header of the current block, qualified by i_valid
//   i_valid        header valid this cycle
//   o_slip         one-cycle gearbox bit-slip command
//   o_block_lock   block lock achieved
//   o_lock_lost    one-cycle pulse, the cycle after o_block_lock falls
//   o_slip_count   saturating count of slips since reset
module pcs_block_lock_ctrl #(
  parameter int SH_CNT_MAX       = 64,
  parameter int SH_INVALID_MAX   = 16,
  parameter int SLIP_WAIT_CYCLES = 32,
  parameter int SLIP_CNT_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_header,
  input  logic                  i_valid,
  output logic                  o_slip,
  output logic                  o_block_lock,
  output logic                  o_lock_lost,
  output logic [SLIP_CNT_W-1:0] o_slip_count
);

  localparam int CNT_W    = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W    = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_RAW = $clog2(SLIP_WAIT_CYCLES + 1);
  localparam int WAIT_W   = (WAIT_RAW < 1) ? 1 : WAIT_RAW;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TEST,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        sh_cnt, sh_cnt_n;
  logic [INV_W-1:0]        sh_invalid_cnt, sh_invalid_cnt_n;
  logic [WAIT_W-1:0]       wait_cnt, wait_cnt_n;
  logic                    lock_n;
  logic                    lock_prev;
  logic [SLIP_CNT_W-1:0]   slip_count_n;

  logic                    sh_valid;
  logic [CNT_W-1:0]        cnt_inc;
  logic [INV_W-1:0]        inv_inc;

  assign sh_valid = i_header[1] ^ i_header[0];
  assign cnt_inc  = sh_cnt + CNT_W'(1);
  assign inv_inc  = sh_invalid_cnt + INV_W'(!sh_valid);

  always_comb begin
    state_n          = state;
    sh_cnt_n         = sh_cnt;
    sh_invalid_cnt_n = sh_invalid_cnt;
    wait_cnt_n       = wait_cnt;
    lock_n           = o_block_lock;
    slip_count_n     = o_slip_count;

    case (state)
      ST_INIT: begin
        lock_n           = 1'b0;
        sh_cnt_n         = '0;
        sh_invalid_cnt_n = '0;
        state_n          = ST_TEST;
      end

      ST_TEST: begin
        if (i_valid) begin
          if (!sh_valid && !o_block_lock) begin
            state_n = ST_SLIP;
          end else if (inv_inc == INV_W'(SH_INVALID_MAX)) begin
            // Takes priority over window completion: a window ending on its
            // limit-reaching bad header still loses lock.
            lock_n  = 1'b0;
            state_n = ST_SLIP;
          end else if (cnt_inc == CNT_W'(SH_CNT_MAX)) begin
            sh_cnt_n         = '0;
            sh_invalid_cnt_n = '0;
            if (inv_inc == '0) begin
              lock_n = 1'b1;
            end
          end else begin
            sh_cnt_n         = cnt_inc;
            sh_invalid_cnt_n = inv_inc;
          end
        end
      end

      ST_SLIP: begin
        if (o_slip_count != {SLIP_CNT_W{1'b1}}) begin
          slip_count_n = o_slip_count + SLIP_CNT_W'(1);
        end
        wait_cnt_n = WAIT_W'(SLIP_WAIT_CYCLES);
        if (SLIP_WAIT_CYCLES == 0) begin
          sh_cnt_n         = '0;
          sh_invalid_cnt_n = '0;
          state_n          = ST_TEST;
        end else begin
          state_n = ST_SLIP_WAIT;
        end
      end

      ST_SLIP_WAIT: begin
        // Counts every cycle, whether or not i_valid is high: the gearbox needs
        // wall-clock time to realign, independent of the block rate.
        if (wait_cnt != '0) begin
          wait_cnt_n = wait_cnt - WAIT_W'(1);
        end
        if (wait_cnt <= WAIT_W'(1)) begin
          sh_cnt_n         = '0;
          sh_invalid_cnt_n = '0;
          state_n          = ST_TEST;
        end
      end

      default: begin
        state_n = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= ST_INIT;
      sh_cnt         <= '0;
      sh_invalid_cnt <= '0;
      wait_cnt       <= '0;
      o_block_lock   <= 1'b0;
      lock_prev      <= 1'b0;
      o_lock_lost    <= 1'b0;
      o_slip         <= 1'b0;
      o_slip_count   <= '0;
    end else begin
      state          <= state_n;
      sh_cnt         <= sh_cnt_n;
      sh_invalid_cnt <= sh_invalid_cnt_n;
      wait_cnt       <= wait_cnt_n;
      o_block_lock   <= lock_n;
      o_slip_count   <= slip_count_n;
      // This is a dedicated flop, rather than a decode of the state bits,
      // so the gearbox sees a glitch-free command.
      o_slip         <= (state_n == ST_SLIP);
      // lock_prev lags o_block_lock by one cycle. As a result, the pulse lands
      // one cycle after the fall is visible.
      lock_prev      <= o_block_lock;
      o_lock_lost    <= lock_prev & ~o_block_lock;
    end
  end

endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// tb/tb_pcs_block_lock_ctrl.sv - self-checking bench for pcs_block_lock_ctrl
module tb_pcs_block_lock_ctrl;

  typedef struct packed {
    logic       slip;
    logic       lock;
    logic       lost;
    logic [7:0] cnt;
  } obs_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [1:0] i_header = 2'b01;
  logic       i_valid = 1'b0;
  logic [1:0] h2 = 2'b01;
  logic       v2 = 1'b0;

  logic       o_slip, o_block_lock, o_lock_lost;
  logic [7:0] o_slip_count;
  logic       o_slip2, o_block_lock2, o_lock_lost2;
  logic [1:0] o_slip_count2;

  obs_t obs1, obs2;
  obs_t exp_q[$];
  obs_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  assign obs1 = {o_slip, o_block_lock, o_lock_lost, o_slip_count};
  assign obs2 = {o_slip2, o_block_lock2, o_lock_lost2, 6'd0, o_slip_count2};

  always #5 i_clk = ~i_clk;

  pcs_block_lock_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_header(i_header), .i_valid(i_valid),
    .o_slip(o_slip), .o_block_lock(o_block_lock), .o_lock_lost(o_lock_lost),
    .o_slip_count(o_slip_count)
  );

  pcs_block_lock_ctrl #(
    .SH_CNT_MAX(64), .SH_INVALID_MAX(16), .SLIP_WAIT_CYCLES(0), .SLIP_CNT_W(2)
  ) dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_header(h2), .i_valid(v2),
    .o_slip(o_slip2), .o_block_lock(o_block_lock2), .o_lock_lost(o_lock_lost2),
    .o_slip_count(o_slip_count2)
  );

  function automatic obs_t mk(input logic s, input logic l, input logic lo, input int c);
    obs_t r;
    r.slip = s; r.lock = l; r.lost = lo; r.cnt = 8'(c);
    return r;
  endfunction

  task automatic tick(input logic [1:0] h, input logic v);
    i_header = h; i_valid = v; v2 = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic tick2(input logic [1:0] h);
    h2 = h; v2 = 1'b1; i_valid = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic lock_up();
    do_reset();
    for (int k = 1; k <= 65; k++) tick(k[0] ? 2'b01 : 2'b10, 1'b1);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL reset_dut got=%h exp=%h", obs1, e); end
    e = exp_q.pop_front(); n_checks++;
    if (obs2 !== e) begin n_fail++; $display("FAIL reset_dut2 got=%h exp=%h", obs2, e); end
    i_reset = 1'b0;
  endtask

  task automatic test_lock_acquire();
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      exp_q.push_back(mk(0, k >= 65, 0, 0));
      tick(k[0] ? 2'b01 : 2'b10, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL lock_acquire k=%0d got=%h exp=%h", k, obs1, e); end
    end
  endtask

  task automatic test_unlocked_slip();
    do_reset();
    for (int t = 1; t <= 11 + 33 + 64; t++) begin
      logic [1:0] h;
      if (t <= 10) begin
        h = 2'b01; exp_q.push_back(mk(0, 0, 0, 0));
      end else if (t == 11) begin
        h = 2'b00; exp_q.push_back(mk(1, 0, 0, 0));
      end else if (t <= 44) begin
        h = 2'b11; exp_q.push_back(mk(0, 0, 0, 1));
      end else begin
        h = 2'b10; exp_q.push_back(mk(0, t == 108, 0, 1));
      end
      tick(h, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL unlocked_slip t=%0d got=%h exp=%h", t, obs1, e); end
    end
  endtask

  task automatic test_locked_invalid();
    lock_up();
    for (int j = 1; j <= 64; j++) begin
      exp_q.push_back(mk(0, 1, 0, 0));
      tick((j % 4 == 0 && j <= 60) ? 2'b11 : 2'b01, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL inv15_hold j=%0d got=%h exp=%h", j, obs1, e); end
    end
    for (int j = 1; j <= 34; j++) begin
      logic [1:0] h;
      if (j < 32)       begin h = (j % 2 == 0) ? 2'b00 : 2'b10; exp_q.push_back(mk(0, 1, 0, 0)); end
      else if (j == 32) begin h = 2'b00; exp_q.push_back(mk(1, 0, 0, 0)); end
      else if (j == 33) begin h = 2'b01; exp_q.push_back(mk(0, 0, 1, 1)); end
      else              begin h = 2'b01; exp_q.push_back(mk(0, 0, 0, 1)); end
      tick(h, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL inv16_slip j=%0d got=%h exp=%h", j, obs1, e); end
    end
  endtask

  task automatic test_last_header();
    lock_up();
    for (int j = 1; j <= 65; j++) begin
      if (j < 64)       exp_q.push_back(mk(0, 1, 0, 0));
      else if (j == 64) exp_q.push_back(mk(1, 0, 0, 0));
      else              exp_q.push_back(mk(0, 0, 1, 1));
      tick((j <= 15 || j == 64) ? 2'b11 : 2'b01, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL last_header j=%0d got=%h exp=%h", j, obs1, e); end
    end
  endtask

  task automatic test_valid_gaps();
    do_reset();
    tick(2'b01, 1'b1);
    for (int t = 1; t <= 130; t++) begin
      exp_q.push_back(mk(0, t >= 127, 0, 0));
      if (t[0]) tick(t[1] ? 2'b01 : 2'b10, 1'b1);
      else      tick(2'b00, 1'b0);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL valid_gaps t=%0d got=%h exp=%h", t, obs1, e); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      int c;
      c = (t - 1) / 2;
      if (c > 3) c = 3;
      exp_q.push_back(mk(t >= 2 && (t % 2 == 0), 0, 0, c));
      tick2(2'b11);
      e = exp_q.pop_front(); n_checks++;
      if (obs2 !== e) begin n_fail++; $display("FAIL back_to_back t=%0d got=%h exp=%h", t, obs2, e); end
    end
  endtask

  task automatic test_reset_mid();
    // Reset asserted while o_slip is high.
    do_reset();
    tick(2'b01, 1'b1);
    exp_q.push_back(mk(1, 0, 0, 0));
    tick(2'b00, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL rst_mid_slip_pre got=%h exp=%h", obs1, e); end
    #2 i_reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL rst_in_slip got=%h exp=%h", obs1, e); end
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Reset asserted during SLIP_WAIT, after the slip counter has advanced.
    tick(2'b01, 1'b1);
    tick(2'b00, 1'b1);
    for (int k = 0; k < 5; k++) tick(2'b01, 1'b1);
    exp_q.push_back(mk(0, 0, 0, 1));
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL rst_mid_wait_pre got=%h exp=%h", obs1, e); end
    #2 i_reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL rst_in_wait got=%h exp=%h", obs1, e); end
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Reset asserted while locked, then relock with no lock-lost pulse.
    lock_up();
    exp_q.push_back(mk(0, 1, 0, 0));
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL rst_mid_lock_pre got=%h exp=%h", obs1, e); end
    #2 i_reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); n_checks++;
    if (obs1 !== e) begin n_fail++; $display("FAIL rst_in_lock got=%h exp=%h", obs1, e); end
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      exp_q.push_back(mk(0, k >= 65, 0, 0));
      tick(k[0] ? 2'b10 : 2'b01, 1'b1);
      e = exp_q.pop_front(); n_checks++;
      if (obs1 !== e) begin n_fail++; $display("FAIL relock k=%0d got=%h exp=%h", k, obs1, e); end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_acquire();
    test_unlocked_slip();
    test_locked_invalid();
    test_last_header();
    test_valid_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
